fuzzify_scheduler: RTL

- Time-multiplexes one combinational trapezoid membership-function (MF) evaluator across N_MF MF shapes.
- Holds a per-MF parameter bank (a,b,c,d, Q7.0 signed), which a host writes over a simple config port.
- On start, latches one crisp input x and evaluates each MF in turn. The evaluator is instantiated at top level and connected through the trap_* ports.
- Streams each membership degree (Q1.15) out with index over a valid/ready handshake, ahead of the rule-evaluation stage.

---
 rtl/fuzzify_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fuzzify_scheduler.sv
// Fuzzifier scheduler: one shared trapezoid evaluator is time-multiplexed across N_MF
// membership functions. A host loads the per-MF breakpoints over the config port.
// A sweep streams one Q1.15 degree per MF, in index order, over a valid/ready handshake.
module fuzzify_scheduler #(
    parameter int unsigned N_MF  = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [7:0]       cfg_a,
    input  logic [7:0]       cfg_b,
    input  logic [7:0]       cfg_c,
    input  logic [7:0]       cfg_d,
    output logic             cfg_err,
    input  logic             start,
    input  logic [7:0]       x_in,
    output logic             busy,
    output logic [7:0]       trap_x,
    output logic [7:0]       trap_a,
    output logic [7:0]       trap_b,
    output logic [7:0]       trap_c,
    output logic [7:0]       trap_d,
    input  logic [15:0]      trap_mu,
    output logic             mu_valid,
    input  logic             mu_ready,
    output logic [15:0]      mu_out,
    output logic [IDX_W-1:0] mu_idx,
    output logic             done
);

    // The bank is addressed with just enough bits for N_MF slots; idx never passes N_MF-1.
    localparam int unsigned SEL_W = (N_MF > 1) ? $clog2(N_MF) : 1;
    localparam int unsigned DEPTH = 1 << SEL_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MF - 1);
    localparam logic [15:0] MU_MAX = 16'h7FFF;

    typedef enum logic [1:0] {StIdle, StEval, StDrain} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         x_q, x_d;
    logic               mu_valid_q, mu_valid_d;
    logic [15:0]        mu_out_q, mu_out_d;
    logic [IDX_W-1:0]   mu_idx_q, mu_idx_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [31:0]        bank_q [DEPTH];
    logic [31:0]        bank_sel;
    logic               cfg_order_ok;
    logic               cfg_ok;

    // A write is legal only from IDLE, to an existing slot, with a<=b<=c<=d (signed).
    always_comb begin
        cfg_order_ok = ($signed(cfg_a) <= $signed(cfg_b)) &&
                       ($signed(cfg_b) <= $signed(cfg_c)) &&
                       ($signed(cfg_c) <= $signed(cfg_d));
        cfg_ok       = (state_q == StIdle) && (cfg_idx <= LAST_IDX) && cfg_order_ok;
    end

    // Breakpoint bank; cleared on reset, updated by accepted config writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (cfg_we && cfg_ok) begin
            bank_q[cfg_idx[SEL_W-1:0]] <= {cfg_a, cfg_b, cfg_c, cfg_d};
        end
    end

    // Evaluator operands come straight from the latched input and the selected bank entry.
    always_comb begin
        bank_sel = bank_q[idx_q[SEL_W-1:0]];
        trap_x   = x_q;
        trap_a   = bank_sel[31:24];
        trap_b   = bank_sel[23:16];
        trap_c   = bank_sel[15:8];
        trap_d   = bank_sel[7:0];
    end

    // Sweep sequencing and output-slot management.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        mu_valid_d = mu_valid_q;
        mu_out_d   = mu_out_q;
        mu_idx_d   = mu_idx_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_we && !cfg_ok;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = x_in;
                    idx_d   = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                // Capture only when the slot is empty or its result leaves this cycle.
                if (!mu_valid_q || mu_ready) begin
                    mu_out_d   = (trap_mu > MU_MAX) ? MU_MAX : trap_mu;
                    mu_idx_d   = idx_q;
                    mu_valid_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = StDrain;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (mu_valid_q && mu_ready) begin
                    mu_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            x_q        <= '0;
            mu_valid_q <= 1'b0;
            mu_out_q   <= '0;
            mu_idx_q   <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            mu_valid_q <= mu_valid_d;
            mu_out_q   <= mu_out_d;
            mu_idx_q   <= mu_idx_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Registered outputs.
    always_comb begin
        busy     = (state_q != StIdle);
        mu_valid = mu_valid_q;
        mu_out   = mu_out_q;
        mu_idx   = mu_idx_q;
        done     = done_q;
        cfg_err  = cfg_err_q;
    end

endmodule
